// File: rtl/pdu_uart_pkg.sv
// rtl/pdu_uart_pkg.sv - shared types and constants for the PDU UART receive path
package pdu_uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Two-out-of-three vote used for mid-bit noise rejection
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pdu_uart_sync.sv
// rtl/pdu_uart_sync.sv - flop-chain synchroniser for asynchronous PDU pin inputs
module pdu_uart_sync #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the pin through the chain; resets to 1 so an idle-high line looks idle
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pdu_uart_rx_sampler.sv
// rtl/pdu_uart_rx_sampler.sv - 8N1 receiver with majority-vote sampling and a one-entry holding register
module pdu_uart_rx_sampler
  import pdu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      uart_rxd,
  output logic [UART_DATA_BITS-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic                      busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      rxd_s;
  logic                      samp0;
  logic                      samp1;
  logic                      maj;
  logic                      at_dec;
  logic                      at_last;
  logic                      stop_ok;

  pdu_uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .d       (uart_rxd),
    .q       (rxd_s)
  );

  // Third vote is the live sample taken in the decision cycle
  assign maj     = maj3(samp0, samp1, rxd_s);
  assign at_dec  = (cnt == CNT_DEC);
  assign at_last = (cnt == CNT_LAST);
  assign stop_ok = (state == STOP) && at_dec && maj;
  assign busy    = (state != IDLE);

  // Capture the two early votes of the mid-bit window
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (cnt == CNT_S0) samp0 <= rxd_s;
      if (cnt == CNT_S1) samp1 <= rxd_s;
    end
  end

  // Frame state machine: start validation, LSB-first shifting, stop check, break hold-off
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      cnt       <= at_last ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxd_s) state <= START;
        end
        START: begin
          if (at_dec && maj) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (at_last) begin
            state <= DATA;
            idx   <= '0;
          end
        end
        DATA: begin
          if (at_dec) shift[idx] <= maj;
          if (at_last) begin
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end
        end
        STOP: begin
          if (at_dec) begin
            cnt <= '0;
            if (maj) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rxd_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Holding register: load on a good stop unless full and stalled, which drops the byte and flags overrun
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_ok && (!out_valid || out_ready)) begin
        out_data  <= shift;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (stop_ok && out_valid && !out_ready) overrun <= 1'b1;
      else if (overrun_clr)                   overrun <= 1'b0;
    end
  end

endmodule
